alu_writeback: RTL and testbench

Stage directly downstream of the ALU. Captures the registered ALU result (acc, c high word, c/z/o flags) one cycle after the control unit issues an op, and sequences the register-file write(s). 32-bit results from MUL6/DIV6 are written as two 16-bit writes. Maintains the architectural flag register, whose carry bit feeds back to the ALU cf input.

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/alu_wb_decode.sv | 55 +++++
 rtl/alu_writeback.sv | 166 ++++++++++++++++
 tb/tb_alu_writeback.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU writeback stage and the ALU issue logic.
//   - opcode constants
//   - writeback FSM state encoding
//   - architectural flag bit indices and flag-update masks
//   - decoded-op record produced by alu_wb_decode
package alu_pkg;

  localparam int OP_BITS = 8;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_ADC  = 8'h02;
  localparam logic [7:0] OP_SUB  = 8'h03;
  localparam logic [7:0] OP_SUC  = 8'h04;
  localparam logic [7:0] OP_MUL8 = 8'h05;
  localparam logic [7:0] OP_MUL6 = 8'h06;
  localparam logic [7:0] OP_DIV8 = 8'h07;
  localparam logic [7:0] OP_DIV6 = 8'h08;
  localparam logic [7:0] OP_CMP  = 8'h09;
  localparam logic [7:0] OP_AND  = 8'h0A;
  localparam logic [7:0] OP_NEG  = 8'h0B;
  localparam logic [7:0] OP_NOT  = 8'h0C;
  localparam logic [7:0] OP_OR   = 8'h0D;
  localparam logic [7:0] OP_SHL  = 8'h0E;
  localparam logic [7:0] OP_SHR  = 8'h0F;
  localparam logic [7:0] OP_XOR  = 8'h10;
  localparam logic [7:0] OP_TEST = 8'h11;

  // Flag register layout is {of, zf, cf}, matching flag_wdata.
  localparam int CF = 0;
  localparam int ZF = 1;
  localparam int OF = 2;

  localparam logic [2:0] MASK_NONE = 3'b000;
  localparam logic [2:0] MASK_Z    = 3'b010;
  localparam logic [2:0] MASK_CZ   = 3'b011;
  localparam logic [2:0] MASK_CZO  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic       wr_lo;      // low word goes to the register file
    logic       wr_hi;      // 32-bit result: second write of the high word
    logic [2:0] flag_mask;  // flags taken from the ALU, {of, zf, cf}
    logic       known;      // opcode recognised (NOP included)
  } wb_dec_t;

endpackage

// File: rtl/alu_wb_decode.sv
// alu_wb_decode: combinational opcode classifier for the writeback stage.
// Ports:
//   op  in  opcode
//   dec out {wr_lo, wr_hi, flag_mask, known}
// Unknown opcodes decode to "no write, no flags, not known".
module alu_wb_decode
  import alu_pkg::*;
(
  input  logic [OP_BITS-1:0] op,
  output wb_dec_t            dec
);

  wb_dec_t dec_s;

  // Opcode -> write/flag behaviour table.
  always_comb begin
    dec_s = '{wr_lo: 1'b0, wr_hi: 1'b0, flag_mask: MASK_NONE, known: 1'b0};
    case (op)
      OP_NOP: begin
        dec_s.known = 1'b1;
      end
      OP_ADD, OP_ADC, OP_SUB, OP_SUC: begin
        dec_s.wr_lo     = 1'b1;
        dec_s.flag_mask = MASK_CZO;
        dec_s.known     = 1'b1;
      end
      OP_MUL6, OP_DIV6: begin
        dec_s.wr_lo     = 1'b1;
        dec_s.wr_hi     = 1'b1;
        dec_s.flag_mask = MASK_Z;
        dec_s.known     = 1'b1;
      end
      OP_MUL8, OP_DIV8, OP_AND, OP_NEG, OP_NOT,
      OP_OR, OP_SHL, OP_SHR, OP_XOR: begin
        dec_s.wr_lo     = 1'b1;
        dec_s.flag_mask = MASK_Z;
        dec_s.known     = 1'b1;
      end
      OP_TEST: begin
        dec_s.flag_mask = MASK_Z;
        dec_s.known     = 1'b1;
      end
      OP_CMP: begin
        dec_s.flag_mask = MASK_CZ;
        dec_s.known     = 1'b1;
      end
      default: begin
        dec_s = '{wr_lo: 1'b0, wr_hi: 1'b0, flag_mask: MASK_NONE, known: 1'b0};
      end
    endcase
  end

  assign dec = dec_s;

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: stage after the ALU. Captures a result one cycle after issue,
// writes it to the register file (two writes for 32-bit MUL6/DIV6 results)
// and maintains the architectural {of, zf, cf} flag register.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             result handshake (ready only in IDLE)
//   in_op, in_dst, in_dst_hi      opcode and destination registers
//   acc, c, c_flag, z_flag, o_flag ALU result words and flags
//   flag_wr, flag_wdata           external flag load {of, zf, cf}
//   rf_we, rf_waddr, rf_wdata     register-file write port
//   cf_out, zf_out, of_out        architectural flags
//   done, bad_op                  end-of-op and unknown-opcode pulses
// All outputs except in_ready are registered; write-port values are computed
// on the edge that enters the state in which they are visible.
module alu_writeback
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int OP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_AW-1:0] in_dst,
  input  logic [REG_AW-1:0] in_dst_hi,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] c,
  input  logic              c_flag,
  input  logic              z_flag,
  input  logic              o_flag,
  input  logic              flag_wr,
  input  logic [2:0]        flag_wdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              cf_out,
  output logic              zf_out,
  output logic              of_out,
  output logic              done,
  output logic              bad_op
);

  wb_state_t          state_r;
  wb_state_t          state_nxt_s;
  wb_dec_t            dec_s;
  logic [REG_AW-1:0]  dst_hi_r;
  logic [DATA_W-1:0]  c_r;
  logic [2:0]         cap_flags_r;
  logic [2:0]         mask_r;
  logic               hi_r;
  logic [2:0]         flags_r;
  logic [2:0]         flags_upd_s;
  logic               rf_we_r;
  logic [REG_AW-1:0]  rf_waddr_r;
  logic [DATA_W-1:0]  rf_wdata_r;
  logic               done_r;
  logic               bad_op_r;

  alu_wb_decode u_decode (
    .op  (in_op),
    .dec (dec_s)
  );

  // Next-state logic and merged flag value for the end of WR_LO.
  always_comb begin
    state_nxt_s = state_r;
    flags_upd_s = (mask_r & cap_flags_r) | (~mask_r & flags_r);
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_nxt_s = WR_LO;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR_LO: begin
        if (hi_r) begin
          state_nxt_s = WR_HI;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR_HI: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register, operand capture, write port, flags and pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      dst_hi_r    <= '0;
      c_r         <= '0;
      cap_flags_r <= 3'b000;
      mask_r      <= 3'b000;
      hi_r        <= 1'b0;
      flags_r     <= 3'b000;
      rf_we_r     <= 1'b0;
      rf_waddr_r  <= '0;
      rf_wdata_r  <= '0;
      done_r      <= 1'b0;
      bad_op_r    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      rf_we_r  <= 1'b0;
      done_r   <= 1'b0;
      bad_op_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            dst_hi_r    <= in_dst_hi;
            c_r         <= c;
            cap_flags_r <= {o_flag, z_flag, c_flag};
            mask_r      <= dec_s.flag_mask;
            hi_r        <= dec_s.wr_hi;
            // Address/data only move with a write so they hold otherwise.
            if (dec_s.wr_lo) begin
              rf_we_r    <= 1'b1;
              rf_waddr_r <= in_dst;
              rf_wdata_r <= acc;
            end
            done_r   <= ~dec_s.wr_hi;
            bad_op_r <= ~dec_s.known;
          end
        end
        WR_LO: begin
          flags_r <= flags_upd_s;
          if (hi_r) begin
            rf_we_r    <= 1'b1;
            rf_waddr_r <= dst_hi_r;
            rf_wdata_r <= c_r;
            done_r     <= 1'b1;
          end
        end
        WR_HI: begin
          hi_r <= 1'b0;
        end
        default: begin
          hi_r <= 1'b0;
        end
      endcase
      // An explicit flag load is later in program order than the op update.
      if (flag_wr) begin
        flags_r <= flag_wdata;
      end
    end
  end

  assign in_ready = (state_r == IDLE);
  assign rf_we    = rf_we_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = rf_wdata_r;
  assign cf_out   = flags_r[CF];
  assign zf_out   = flags_r[ZF];
  assign of_out   = flags_r[OF];
  assign done     = done_r;
  assign bad_op   = bad_op_r;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback. Expected register-file writes are
// queued when an op is driven and compared by a monitor when rf_we is seen;
// flags and pulses are checked at directed points. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_op;
  logic [2:0]  in_dst;
  logic [2:0]  in_dst_hi;
  logic [15:0] acc;
  logic [15:0] c;
  logic        c_flag;
  logic        z_flag;
  logic        o_flag;
  logic        flag_wr;
  logic [2:0]  flag_wdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        cf_out;
  logic        zf_out;
  logic        of_out;
  logic        done;
  logic        bad_op;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  compared   = 0;
  int  mismatched = 0;

  always #5 clk = ~clk;

  alu_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_dst     (in_dst),
    .in_dst_hi  (in_dst_hi),
    .acc        (acc),
    .c          (c),
    .c_flag     (c_flag),
    .z_flag     (z_flag),
    .o_flag     (o_flag),
    .flag_wr    (flag_wr),
    .flag_wdata (flag_wdata),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .cf_out     (cf_out),
    .zf_out     (zf_out),
    .of_out     (of_out),
    .done       (done),
    .bad_op     (bad_op)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every observed write must match the oldest queued one.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {13'd0, rf_waddr, rf_wdata}, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {29'd0, rf_waddr}, {29'd0, e.addr});
        chk("wr_data", {16'd0, rf_wdata}, {16'd0, e.data});
      end
    end
  end

  // Drive one result at a falling edge; returns at the falling edge of cycle N+1.
  task automatic issue(input logic [7:0] op, input logic [2:0] dst, input logic [2:0] dhi,
                       input logic [15:0] a, input logic [15:0] hw,
                       input logic cf, input logic of);
    in_valid  = 1'b1;
    in_op     = op;
    in_dst    = dst;
    in_dst_hi = dhi;
    acc       = a;
    c         = hw;
    c_flag    = cf;
    o_flag    = of;
    z_flag    = (a == 16'h0000);
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, of_out, zf_out, cf_out}, {29'd0, exp});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = 8'h00; in_dst = 3'd0; in_dst_hi = 3'd0;
    acc = 16'h0000; c = 16'h0000; c_flag = 1'b0; z_flag = 1'b0; o_flag = 1'b0;
    flag_wr = 1'b0; flag_wdata = 3'b000;
    @(negedge clk); @(negedge clk);
    chk("rst_we", rf_we, 1'b0);
    chk("rst_waddr", rf_waddr, 3'd0);
    chk("rst_wdata", rf_wdata, 16'h0000);
    chk_flags("rst_flags", 3'b000);
    chk("rst_done", done, 1'b0);
    chk("rst_bad", bad_op, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // ADD r2 = 0, carry out, zero
    exp_q.push_back('{addr: 3'd2, data: 16'h0000});
    issue(8'h01, 3'd2, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    chk("add_we", rf_we, 1'b1);
    chk("add_done", done, 1'b1);
    chk("add_ready_busy", in_ready, 1'b0);
    @(negedge clk);
    chk("add_ready", in_ready, 1'b1);
    chk_flags("add_flags", 3'b011);
    chk("add_done_clr", done, 1'b0);

    // MUL6 r3:r1 = 0x1234_5678; ALU cf/of differ from current flags
    exp_q.push_back('{addr: 3'd1, data: 16'h5678});
    exp_q.push_back('{addr: 3'd3, data: 16'h1234});
    issue(8'h06, 3'd1, 3'd3, 16'h5678, 16'h1234, 1'b0, 1'b1);
    chk("mul6_lo_we", rf_we, 1'b1);
    chk("mul6_lo_done", done, 1'b0);
    @(negedge clk);
    chk("mul6_hi_we", rf_we, 1'b1);
    chk("mul6_hi_done", done, 1'b1);
    chk_flags("mul6_flags", 3'b001);
    @(negedge clk);
    chk("mul6_ready", in_ready, 1'b1);
    chk("mul6_we_clr", rf_we, 1'b0);

    // External flag load in IDLE
    flag_wr = 1'b1; flag_wdata = 3'b100;
    @(negedge clk);
    flag_wr = 1'b0;
    chk_flags("flagwr_idle", 3'b100);

    // CMP: cf and zf from ALU, of kept
    issue(8'h09, 3'd4, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    chk("cmp_we", rf_we, 1'b0);
    chk("cmp_done", done, 1'b1);
    @(negedge clk);
    chk_flags("cmp_flags", 3'b111);

    // Unknown opcode
    issue(8'h3F, 3'd5, 3'd0, 16'h0001, 16'h0000, 1'b0, 1'b0);
    chk("bad_we", rf_we, 1'b0);
    chk("bad_pulse", bad_op, 1'b1);
    chk("bad_done", done, 1'b1);
    @(negedge clk);
    chk("bad_clr", bad_op, 1'b0);
    chk_flags("bad_flags", 3'b111);
    chk("bad_ready", in_ready, 1'b1);
    chk("hold_waddr", rf_waddr, 3'd3);
    chk("hold_wdata", rf_wdata, 16'h1234);

    // NOP: known, no write, no flag change
    issue(8'h00, 3'd6, 3'd0, 16'h0001, 16'h0000, 1'b0, 1'b0);
    chk("nop_we", rf_we, 1'b0);
    chk("nop_bad", bad_op, 1'b0);
    chk("nop_done", done, 1'b1);
    @(negedge clk);
    chk_flags("nop_flags", 3'b111);

    // SUB with a coincident flag load in WR_LO: flag load wins
    exp_q.push_back('{addr: 3'd5, data: 16'h00FF});
    issue(8'h03, 3'd5, 3'd0, 16'h00FF, 16'h0000, 1'b1, 1'b1);
    chk("sub_we", rf_we, 1'b1);
    flag_wr = 1'b1; flag_wdata = 3'b000;
    @(negedge clk);
    flag_wr = 1'b0;
    chk_flags("sub_flagwr_wins", 3'b000);

    // ADC with varied operands: all three flags follow the ALU
    for (int i = 0; i < 4; i++) begin
      logic [15:0] a;
      logic        cf, of;
      a  = (i == 2) ? 16'h0000 : 16'($urandom_range(1, 65535));
      cf = 1'($urandom_range(0, 1));
      of = 1'(i & 1);
      exp_q.push_back('{addr: 3'(i), data: a});
      issue(8'h02, 3'(i), 3'd0, a, 16'h0000, cf, of);
      @(negedge clk);
      chk_flags("adc_flags", {of, (a == 16'h0000), cf});
    end

    // Reset during WR_LO of a MUL6 aborts the high write
    flag_wr = 1'b1; flag_wdata = 3'b101;
    @(negedge clk);
    flag_wr = 1'b0;
    exp_q.push_back('{addr: 3'd6, data: 16'hAAAA});
    issue(8'h06, 3'd6, 3'd7, 16'hAAAA, 16'h5555, 1'b1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_we", rf_we, 1'b0);
    chk("abort_ready", in_ready, 1'b1);
    chk_flags("abort_flags", 3'b000);
    chk("abort_waddr", rf_waddr, 3'd0);
    chk("abort_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_no_hi", rf_we, 1'b0);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
